// File: rtl/avmm_arb_pkg.sv
// Shared types for the two-port AVMM burst arbiter: grant id, FSM states and
// the read-tag record that steers returning read beats.
package avmm_arb_pkg;

  localparam int NUM_PORTS   = 2;
  // Wide enough for any legal Avalon burstcount; narrower counts zero-extend.
  localparam int TAG_BEATS_W = 11;

  typedef logic port_id_t;

  typedef enum logic {ARB, WLOCK} arb_state_t;

  typedef struct packed {
    port_id_t               port;
    logic [TAG_BEATS_W-1:0] beats;
  } rd_tag_t;

endpackage

// File: rtl/avmm_arb_tag_fifo.sv
// In-order FIFO of outstanding read tags; a pop and a push may share a cycle,
// but a push is refused whenever the FIFO is full at the start of the cycle.
module avmm_arb_tag_fifo
  import avmm_arb_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  rd_tag_t din,
  output rd_tag_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  rd_tag_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/avmm_burst_arb.sv
// Two-master AVMM arbiter: per-command round robin, write bursts locked to
// their owner until the last beat, read beats steered back by an in-order tag FIFO.
module avmm_burst_arb
  import avmm_arb_pkg::*;
#(
  parameter int ADDRESS_W    = 26,
  parameter int DATA_W       = 512,
  parameter int BYTEENABLE_W = DATA_W/8,
  parameter int BURSTCOUNT_W = 7,
  parameter int TAG_DEPTH    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    avs0_read,
  input  logic                    avs0_write,
  input  logic [ADDRESS_W-1:0]    avs0_address,
  input  logic [BYTEENABLE_W-1:0] avs0_byteenable,
  input  logic [BURSTCOUNT_W-1:0] avs0_burstcount,
  input  logic [DATA_W-1:0]       avs0_writedata,
  output logic                    avs0_waitrequest,
  output logic [DATA_W-1:0]       avs0_readdata,
  output logic                    avs0_readdatavalid,
  input  logic                    avs1_read,
  input  logic                    avs1_write,
  input  logic [ADDRESS_W-1:0]    avs1_address,
  input  logic [BYTEENABLE_W-1:0] avs1_byteenable,
  input  logic [BURSTCOUNT_W-1:0] avs1_burstcount,
  input  logic [DATA_W-1:0]       avs1_writedata,
  output logic                    avs1_waitrequest,
  output logic [DATA_W-1:0]       avs1_readdata,
  output logic                    avs1_readdatavalid,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [ADDRESS_W-1:0]    avm_address,
  output logic [BYTEENABLE_W-1:0] avm_byteenable,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  output logic [DATA_W-1:0]       avm_writedata,
  input  logic                    avm_waitrequest,
  input  logic [DATA_W-1:0]       avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic                    rsp_err
);

  logic [NUM_PORTS-1:0]                   rd, wr, req;
  logic [NUM_PORTS-1:0][ADDRESS_W-1:0]    addr;
  logic [NUM_PORTS-1:0][BYTEENABLE_W-1:0] be;
  logic [NUM_PORTS-1:0][BURSTCOUNT_W-1:0] bc;
  logic [NUM_PORTS-1:0][DATA_W-1:0]       wdata;

  assign rd    = {avs1_read, avs0_read};
  assign wr    = {avs1_write, avs0_write};
  assign req   = rd | wr;
  assign addr  = {avs1_address, avs0_address};
  assign be    = {avs1_byteenable, avs0_byteenable};
  assign bc    = {avs1_burstcount, avs0_burstcount};
  assign wdata = {avs1_writedata, avs0_writedata};

  arb_state_t              state_q, state_d;
  port_id_t                last_grant_q, last_grant_d, lock_port_q, lock_port_d;
  logic [BURSTCOUNT_W-1:0] wbeats_q, wbeats_d;
  logic [TAG_BEATS_W-1:0]  rbeats_q, rbeats_d, cur_beats;
  logic                    rsp_err_q, rsp_err_d;

  port_id_t                grant;
  logic                    gnt_vld, rd_block, gnt_wait, rd_acc, wr_acc, rsp_hit, tag_pop;
  logic [BURSTCOUNT_W-1:0] bc_eff;
  rd_tag_t                 tag_head, tag_din;
  logic                    tag_full, tag_empty;

  avmm_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_acc),
    .pop   (tag_pop),
    .din   (tag_din),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign avs0_readdata = avm_readdata;
  assign avs1_readdata = avm_readdata;
  assign rsp_err       = rsp_err_q;

  // Command path: grant, muxing and waitrequest are all same-cycle.
  always_comb begin
    if (state_q == WLOCK) begin
      grant   = lock_port_q;
      gnt_vld = 1'b1;
    end else begin
      grant   = (&req) ? ~last_grant_q : req[1];
      gnt_vld = |req;
    end
    rd_block         = (state_q == WLOCK) || tag_full;
    avm_read         = rst_n && gnt_vld && rd[grant] && !rd_block;
    avm_write        = rst_n && gnt_vld && wr[grant];
    avm_address      = addr[grant];
    avm_byteenable   = be[grant];
    avm_burstcount   = bc[grant];
    avm_writedata    = wdata[grant];
    gnt_wait         = avm_waitrequest || (rd[grant] && rd_block);
    avs0_waitrequest = !(rst_n && gnt_vld && !grant) || gnt_wait;
    avs1_waitrequest = !(rst_n && gnt_vld && grant) || gnt_wait;
    rd_acc           = avm_read && !avm_waitrequest;
    wr_acc           = avm_write && !avm_waitrequest;
    bc_eff           = (bc[grant] == '0) ? BURSTCOUNT_W'(1) : bc[grant];
    tag_din          = '{port: grant, beats: TAG_BEATS_W'(bc_eff)};

    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_port_d  = lock_port_q;
    wbeats_d     = wbeats_q;
    if (state_q == ARB) begin
      if (rd_acc) begin
        last_grant_d = grant;
      end else if (wr_acc) begin
        if (bc_eff > BURSTCOUNT_W'(1)) begin
          state_d     = WLOCK;
          lock_port_d = grant;
          wbeats_d    = bc_eff - BURSTCOUNT_W'(1);
        end else begin
          last_grant_d = grant;
        end
      end
    end else if (wr_acc) begin
      wbeats_d = wbeats_q - BURSTCOUNT_W'(1);
      if (wbeats_q == BURSTCOUNT_W'(1)) begin
        state_d      = ARB;
        last_grant_d = lock_port_q;
      end
    end

    // rbeats_q==0 means the head tag has not returned any beat yet.
    cur_beats          = (rbeats_q == '0) ? tag_head.beats : rbeats_q;
    rsp_hit            = rst_n && avm_readdatavalid && !tag_empty;
    tag_pop            = rsp_hit && (cur_beats == TAG_BEATS_W'(1));
    rbeats_d           = rbeats_q;
    if (rsp_hit) rbeats_d = tag_pop ? '0 : cur_beats - TAG_BEATS_W'(1);
    avs0_readdatavalid = rsp_hit && !tag_head.port;
    avs1_readdatavalid = rsp_hit && tag_head.port;
    rsp_err_d          = rsp_err_q || (avm_readdatavalid && tag_empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB;
      last_grant_q <= 1'b0;
      lock_port_q  <= 1'b0;
      wbeats_q     <= '0;
      rbeats_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_port_q  <= lock_port_d;
      wbeats_q     <= wbeats_d;
      rbeats_q     <= rbeats_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_avmm_burst_arb.sv
// Bench for avmm_burst_arb: vector table, directed corner sequences, then
// random two-master traffic against a transaction-level model.
module tb_avmm_burst_arb;
  import avmm_arb_pkg::*;

  localparam int AW = 26, DW = 32, BEW = 4, BCW = 7, TD = 4;
  localparam logic [AW-1:0] A0 = 26'h100, A1 = 26'h200;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic avs0_read, avs0_write, avs0_waitrequest, avs0_readdatavalid;
  logic avs1_read, avs1_write, avs1_waitrequest, avs1_readdatavalid;
  logic [AW-1:0] avs0_address, avs1_address, avm_address;
  logic [BEW-1:0] avs0_byteenable, avs1_byteenable, avm_byteenable;
  logic [BCW-1:0] avs0_burstcount, avs1_burstcount, avm_burstcount;
  logic [DW-1:0] avs0_writedata, avs1_writedata, avs0_readdata, avs1_readdata;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic avm_read, avm_write, avm_waitrequest, avm_readdatavalid, rsp_err;

  avmm_burst_arb #(.ADDRESS_W(AW), .DATA_W(DW), .BYTEENABLE_W(BEW),
                   .BURSTCOUNT_W(BCW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .avs0_read(avs0_read), .avs0_write(avs0_write), .avs0_address(avs0_address),
    .avs0_byteenable(avs0_byteenable), .avs0_burstcount(avs0_burstcount),
    .avs0_writedata(avs0_writedata), .avs0_waitrequest(avs0_waitrequest),
    .avs0_readdata(avs0_readdata), .avs0_readdatavalid(avs0_readdatavalid),
    .avs1_read(avs1_read), .avs1_write(avs1_write), .avs1_address(avs1_address),
    .avs1_byteenable(avs1_byteenable), .avs1_burstcount(avs1_burstcount),
    .avs1_writedata(avs1_writedata), .avs1_waitrequest(avs1_waitrequest),
    .avs1_readdata(avs1_readdata), .avs1_readdatavalid(avs1_readdatavalid),
    .avm_read(avm_read), .avm_write(avm_write), .avm_address(avm_address),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .rsp_err(rsp_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    avs0_read = 0; avs0_write = 0; avs0_address = A0; avs0_burstcount = 1;
    avs1_read = 0; avs1_write = 0; avs1_address = A1; avs1_burstcount = 1;
    avs0_byteenable = '1; avs1_byteenable = '1;
    avs0_writedata = 32'hA0A0_0000; avs1_writedata = 32'hB1B1_0000;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 32'hDEAD_BEEF;
  endtask

  // One cycle of reset with live requests; outputs must stay quiet meanwhile.
  task automatic do_reset(input bit check);
    rst_n = 0; avs0_read = 1; avs1_write = 1; avm_readdatavalid = 1;
    #3;
    if (check) begin
      chk("rst_w0", avs0_waitrequest, 1);
      chk("rst_w1", avs1_waitrequest, 1);
      chk("rst_avm_rd", avm_read, 0);
      chk("rst_avm_wr", avm_write, 0);
      chk("rst_v0", avs0_readdatavalid, 0);
      chk("rst_v1", avs1_readdatavalid, 0);
    end
    cyc();
    clear_inputs();
    rst_n = 1;
    chk("rst_err", rsp_err, 0);
  endtask

  typedef struct {
    logic rd0, wr0, rd1, wr1;
    logic [BCW-1:0] bc0, bc1;
    logic mwait, mrdv;
    logic e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [BCW-1:0] e_bc;
    logic e_w0, e_w1, e_v0, e_v1;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input logic rd0, wr0, rd1, wr1, input int bc0, bc1,
                              input logic mwait, mrdv, e_rd, e_wr,
                              input logic [AW-1:0] e_addr, input int e_bc,
                              input logic e_w0, e_w1, e_v0, e_v1);
    vec_t v;
    v.rd0 = rd0; v.wr0 = wr0; v.rd1 = rd1; v.wr1 = wr1;
    v.bc0 = BCW'(bc0); v.bc1 = BCW'(bc1); v.mwait = mwait; v.mrdv = mrdv;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_bc = BCW'(e_bc);
    v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_v0 = e_v0; v.e_v1 = e_v1;
    return v;
  endfunction

  // Random-phase master and model state.
  bit              m_rd[2], m_wr[2];
  int              m_bc[2], m_left[2], m_age[2];
  logic [AW-1:0]   m_addr[2];
  logic [DW-1:0]   m_data[2];
  int              q_port[$], q_beats[$];
  int              lk_port, lk_left, last, max_age;
  bit              acc[2];

  task automatic new_cmd(input int p);
    if ($urandom_range(0, 3) == 0) return;
    m_rd[p]   = $urandom_range(0, 1);
    m_wr[p]   = !m_rd[p];
    m_bc[p]   = $urandom_range(0, 4);
    m_left[p] = (m_bc[p] == 0) ? 1 : m_bc[p];
    m_addr[p] = AW'($urandom);
    m_data[p] = $urandom;
  endtask

  task automatic drive_masters();
    avs0_read = m_rd[0]; avs0_write = m_wr[0]; avs0_address = m_addr[0];
    avs0_burstcount = BCW'(m_bc[0]); avs0_writedata = m_data[0];
    avs1_read = m_rd[1]; avs1_write = m_wr[1]; avs1_address = m_addr[1];
    avs1_burstcount = BCW'(m_bc[1]); avs1_writedata = m_data[1];
  endtask

  // One random cycle: inputs already driven, sample mid-cycle, update model.
  task automatic rnd_cycle(input bit allow_new);
    int eff;
    bit both;
    for (int p = 0; p < 2; p++) if (allow_new && !m_rd[p] && !m_wr[p]) new_cmd(p);
    drive_masters();
    avm_waitrequest   = ($urandom_range(0, 3) == 0);
    avm_readdatavalid = (q_port.size() > 0) && ($urandom_range(0, 1) == 1);
    avm_readdata      = $urandom;
    #3;
    if (avm_readdatavalid) begin
      chk("rnd_v0", avs0_readdatavalid, q_port[0] == 0);
      chk("rnd_v1", avs1_readdatavalid, q_port[0] == 1);
      chk("rnd_rdata", avs1_readdata, avm_readdata);
      q_beats[0] = q_beats[0] - 1;
      if (q_beats[0] == 0) begin
        void'(q_port.pop_front());
        void'(q_beats.pop_front());
      end
    end else begin
      chk("rnd_v_idle", {avs1_readdatavalid, avs0_readdatavalid}, 0);
    end
    acc[0] = (m_rd[0] || m_wr[0]) && !avs0_waitrequest;
    acc[1] = (m_rd[1] || m_wr[1]) && !avs1_waitrequest;
    chk("rnd_one_acc", acc[0] && acc[1], 0);
    chk("rnd_spurious", (avm_read || avm_write) && !avm_waitrequest, acc[0] || acc[1]);
    both = (m_rd[0] || m_wr[0]) && (m_rd[1] || m_wr[1]);
    if (lk_left == 0 && both)
      chk("rnd_fair", (last == 0) ? avs0_waitrequest : avs1_waitrequest, 1);
    for (int p = 0; p < 2; p++) begin
      if (!acc[p]) begin
        if (m_rd[p] || m_wr[p]) m_age[p]++;
        if (m_age[p] > max_age) max_age = m_age[p];
        continue;
      end
      m_age[p] = 0;
      chk("rnd_cmd", {avm_read, avm_write}, {m_rd[p], m_wr[p]});
      chk("rnd_addr", avm_address, m_addr[p]);
      chk("rnd_bc", avm_burstcount, BCW'(m_bc[p]));
      if (m_wr[p]) chk("rnd_wdata", avm_writedata, m_data[p]);
      eff = (m_bc[p] == 0) ? 1 : m_bc[p];
      if (lk_left > 0) begin
        chk("rnd_lock", (p == lk_port) && m_wr[p], 1);
        lk_left--;
        if (lk_left == 0) last = lk_port;
      end else if (m_rd[p]) begin
        q_port.push_back(p);
        q_beats.push_back(eff);
        last = p;
      end else if (eff > 1) begin
        lk_port = p;
        lk_left = eff - 1;
      end else begin
        last = p;
      end
      if (m_wr[p] && m_left[p] > 1) begin
        m_left[p]--;
        m_data[p] = $urandom;
      end else begin
        m_rd[p] = 0;
        m_wr[p] = 0;
      end
    end
    cyc();
  endtask

  initial begin
    int route[6];
    bit drained;
    clear_inputs();
    do_reset(1);

    // Vector table; FIFO depth 4 fills at vector 10.
    vt.push_back(mk(0,0,0,1, 1,1, 0,0, 0,1, A1,1, 1,0,0,0));
    vt.push_back(mk(0,1,0,0, 1,1, 0,0, 0,1, A0,1, 0,1,0,0));
    vt.push_back(mk(0,1,0,1, 1,1, 0,0, 0,1, A1,1, 1,0,0,0));
    vt.push_back(mk(0,1,0,1, 1,1, 0,0, 0,1, A0,1, 0,1,0,0));
    vt.push_back(mk(0,1,0,1, 1,1, 1,0, 0,1, A1,1, 1,1,0,0));
    vt.push_back(mk(0,1,0,1, 1,1, 0,0, 0,1, A1,1, 1,0,0,0));
    vt.push_back(mk(1,0,0,0, 3,1, 0,0, 1,0, A0,3, 0,1,0,0));
    vt.push_back(mk(0,0,1,0, 1,2, 0,0, 1,0, A1,2, 1,0,0,0));
    vt.push_back(mk(1,0,0,0, 0,1, 0,0, 1,0, A0,0, 0,1,0,0));
    vt.push_back(mk(0,0,1,0, 1,1, 0,0, 1,0, A1,1, 1,0,0,0));
    vt.push_back(mk(1,0,0,1, 1,1, 0,0, 0,0, A0,1, 1,1,0,0));
    vt.push_back(mk(0,1,0,0, 1,1, 0,0, 0,1, A0,1, 0,1,0,0));
    vt.push_back(mk(0,0,0,0, 1,1, 0,1, 0,0, A0,1, 1,1,1,0));
    vt.push_back(mk(0,0,0,0, 1,1, 0,1, 0,0, A0,1, 1,1,1,0));
    vt.push_back(mk(0,0,0,0, 1,1, 0,1, 0,0, A0,1, 1,1,1,0));
    vt.push_back(mk(0,0,0,0, 1,1, 0,1, 0,0, A0,1, 1,1,0,1));
    vt.push_back(mk(0,0,0,0, 1,1, 0,1, 0,0, A0,1, 1,1,0,1));
    vt.push_back(mk(0,0,0,0, 1,1, 0,1, 0,0, A0,1, 1,1,1,0));
    vt.push_back(mk(0,0,0,0, 1,1, 0,1, 0,0, A0,1, 1,1,0,1));
    vt.push_back(mk(0,0,0,0, 1,1, 0,1, 0,0, A0,1, 1,1,0,0));
    foreach (vt[i]) begin
      avs0_read = vt[i].rd0; avs0_write = vt[i].wr0; avs0_burstcount = vt[i].bc0;
      avs1_read = vt[i].rd1; avs1_write = vt[i].wr1; avs1_burstcount = vt[i].bc1;
      avm_waitrequest = vt[i].mwait; avm_readdatavalid = vt[i].mrdv;
      #3;
      chk($sformatf("vec%0d_rd", i), avm_read, vt[i].e_rd);
      chk($sformatf("vec%0d_wr", i), avm_write, vt[i].e_wr);
      if (vt[i].e_rd || vt[i].e_wr) begin
        chk($sformatf("vec%0d_addr", i), avm_address, vt[i].e_addr);
        chk($sformatf("vec%0d_bc", i), avm_burstcount, vt[i].e_bc);
      end
      if (vt[i].rd0 || vt[i].wr0 || vt[i].rd1 || vt[i].wr1) begin
        chk($sformatf("vec%0d_w0", i), avs0_waitrequest, vt[i].e_w0);
        chk($sformatf("vec%0d_w1", i), avs1_waitrequest, vt[i].e_w1);
      end
      chk($sformatf("vec%0d_v0", i), avs0_readdatavalid, vt[i].e_v0);
      chk($sformatf("vec%0d_v1", i), avs1_readdatavalid, vt[i].e_v1);
      cyc();
    end
    clear_inputs();
    chk("vec_err_sticky", rsp_err, 1);
    do_reset(0);

    // Stray response on an empty FIFO, sticky until a one-cycle reset.
    avm_readdatavalid = 1;
    #3 chk("err_v", {avs1_readdatavalid, avs0_readdatavalid}, 0);
    cyc();
    avm_readdatavalid = 0;
    chk("err_set", rsp_err, 1);
    cyc(); cyc(); cyc();
    chk("err_hold", rsp_err, 1);
    do_reset(0);

    // Port1 write burst of 8; port0 read arrives at beat 2 and must wait.
    avs1_write = 1; avs1_burstcount = 8;
    for (int k = 0; k < 8; k++) begin
      if (k >= 1) avs0_read = 1;
      avs1_writedata = DW'(k);
      #3;
      chk("lock_w1", avs1_waitrequest, 0);
      chk("lock_bc", avm_burstcount, 8);
      chk("lock_wdata", avm_writedata, DW'(k));
      if (k >= 1) begin
        chk("lock_w0", avs0_waitrequest, 1);
        chk("lock_rd", avm_read, 0);
      end
      cyc();
    end
    avs1_write = 0;
    #3;
    chk("lock_rel_rd", avm_read, 1);
    chk("lock_rel_w0", avs0_waitrequest, 0);
    chk("lock_rel_addr", avm_address, A0);
    cyc();
    clear_inputs();
    do_reset(0);

    // Interleaved reads p0 bc2, p1 bc3, p0 bc1; beats route p0,p0,p1,p1,p1,p0.
    avs0_read = 1; avs0_burstcount = 2;
    #3 chk("il_w0a", avs0_waitrequest, 0);
    cyc();
    avs0_read = 0; avs1_read = 1; avs1_burstcount = 3;
    #3 chk("il_w1", avs1_waitrequest, 0);
    cyc();
    avs1_read = 0; avs0_read = 1; avs0_burstcount = 1;
    #3 chk("il_w0b", avs0_waitrequest, 0);
    cyc();
    clear_inputs();
    route = '{0, 0, 1, 1, 1, 0};
    for (int k = 0; k < 6; k++) begin
      avm_readdatavalid = 1;
      #3;
      chk($sformatf("il_v0_%0d", k), avs0_readdatavalid, route[k] == 0);
      chk($sformatf("il_v1_%0d", k), avs1_readdatavalid, route[k] == 1);
      cyc();
    end
    avm_readdatavalid = 0;
    chk("il_err", rsp_err, 0);
    do_reset(0);

    // Tag FIFO full: 5th read waits until a last-beat pop frees a slot.
    avs0_read = 1;
    for (int k = 0; k < 4; k++) begin
      #3 chk($sformatf("full_acc%0d", k), avs0_waitrequest, 0);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      #3;
      chk("full_w0", avs0_waitrequest, 1);
      chk("full_rd", avm_read, 0);
      cyc();
    end
    avm_readdatavalid = 1;
    #3;
    chk("full_pop_v0", avs0_readdatavalid, 1);
    chk("full_pop_w0", avs0_waitrequest, 1);
    cyc();
    avm_readdatavalid = 0;
    #3;
    chk("full_rel_w0", avs0_waitrequest, 0);
    chk("full_rel_rd", avm_read, 1);
    cyc();
    clear_inputs();
    do_reset(0);

    // Random traffic against the transaction model.
    last = 0; lk_left = 0; lk_port = 0; max_age = 0;
    for (int p = 0; p < 2; p++) begin
      m_rd[p] = 0; m_wr[p] = 0; m_age[p] = 0; m_bc[p] = 1; m_left[p] = 0;
      m_addr[p] = '0; m_data[p] = '0;
    end
    for (int c = 0; c < 3000; c++) rnd_cycle(1);
    drained = 0;
    for (int c = 0; c < 500 && !drained; c++) begin
      rnd_cycle(0);
      drained = !m_rd[0] && !m_wr[0] && !m_rd[1] && !m_wr[1] && q_port.size() == 0;
    end
    chk("rnd_drained", drained, 1);
    chk("rnd_err", rsp_err, 0);
    checks++;
    if (max_age > 300) begin
      errors++;
      $display("FAIL rnd_starve: longest wait %0d cycles, limit 300", max_age);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
